// File: rtl/filtered_image_uart_tx_pkg.sv
// filtered_image_uart_pkg: shared definitions for the filtered-image UART dump path
//   state_t   : FSM states used by the readout controller and the byte serialiser
//   calc_div  : clock cycles per UART bit (CLK_FREQ/BAUD, truncated)
//   UART_IDLE : line level while nothing is being sent
package filtered_image_uart_pkg;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, STOP, CHK, DONE} state_t;
   localparam logic UART_IDLE = 1'b1;
   function automatic int calc_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction
endpackage

// File: rtl/filtered_image_uart_tx_if.sv
// filtered_image_uart_tx_if: data-memory secondary read port
//   mem_addr : byte read address
//   mem_r_en : read strobe, data returns one cycle later
//   mem_data : read data
//   master   : the readout block; slave : the memory
interface filtered_image_uart_tx_if #(parameter int ADDR_W = 32);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_r_en;
   logic [7:0]        mem_data;
   modport master (output mem_addr, mem_r_en, input mem_data);
   modport slave  (input mem_addr, mem_r_en, output mem_data);
endinterface

// File: rtl/filtered_image_uart_tx_uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser, one byte per i_valid, each bit held DIV cycles
//   clk, rst (async, active low), i_valid/i_byte : byte to send (taken only when idle)
//   o_tx    : UART line, idle high
//   o_ready : idle, or in the last cycle of the stop bit (next byte may follow back to back)
module uart_tx_byte
   import filtered_image_uart_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_valid,
   input  logic [7:0] i_byte,
   output logic       o_tx,
   output logic       o_ready
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   state_t        phase_q, phase_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [9:0]    shift_q, shift_d;
   logic          tick;
   always_comb begin
      tick    = cnt_q == CW'(DIV - 1);
      phase_d = phase_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      if (phase_q == IDLE) begin
         cnt_d = '0;
         bit_d = '0;
         if (i_valid) begin
            phase_d = START;
            shift_d = {UART_IDLE, i_byte, 1'b0};
         end
      end else if (tick) begin
         cnt_d   = '0;
         shift_d = {UART_IDLE, shift_q[9:1]};
         bit_d   = phase_q == DATA ? bit_q + 3'd1 : '0;
         phase_d = phase_q == START ? DATA : phase_q == STOP ? IDLE : bit_q == 3'd7 ? STOP : DATA;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '1;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end
   assign o_tx    = phase_q == IDLE ? UART_IDLE : shift_q[0];
   assign o_ready = phase_q == IDLE || (phase_q == STOP && tick);
endmodule

// File: rtl/filtered_image_uart_tx.sv
// filtered_image_uart_tx: reads an h x w region of filtered pixels and dumps it over 8N1 UART
//   clk, rst (async, active low)
//   i_start/i_base_addr/i_h/i_w : dump request, latched in IDLE
//   mem   : data-memory secondary read port (master side)
//   o_tx  : UART line; o_busy : dump in progress; o_done : one-cycle end pulse
//   UART_TX_CHECKSUM_EN : append the XOR of all pixel bytes as a trailing character
module filtered_image_uart_tx
   import filtered_image_uart_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115_200,
   parameter int ADDR_W   = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_start,
   input  logic [ADDR_W-1:0]          i_base_addr,
   input  logic [7:0]                 i_h,
   input  logic [7:0]                 i_w,
   filtered_image_uart_tx_if.master   mem,
   output logic                       o_tx,
   output logic                       o_busy,
   output logic                       o_done
);
   localparam int DIV = calc_div(CLK_FREQ, BAUD);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [15:0]       total_q, total_d, idx_q, idx_d;
   logic              tx_valid, tx_ready, more;
   logic [7:0]        tx_byte;
`ifdef UART_TX_CHECKSUM_EN
   logic [7:0]        chk_q, chk_d;
   logic              chk_sent_q, chk_sent_d;
`endif
   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      total_d  = total_q;
      idx_d    = idx_q;
      tx_valid = 1'b0;
      tx_byte  = mem.mem_data;
      more     = idx_q + 16'd1 < total_q;
`ifdef UART_TX_CHECKSUM_EN
      chk_d      = chk_q;
      chk_sent_d = chk_sent_q;
`endif
      case (state_q)
         IDLE: if (i_start) begin
            base_d  = i_base_addr;
            total_d = 16'(i_h) * 16'(i_w);
            idx_d   = '0;
`ifdef UART_TX_CHECKSUM_EN
            chk_d      = '0;
            chk_sent_d = 1'b0;
            state_d    = total_d == '0 ? CHK : REQ;
`else
            state_d = total_d == '0 ? DONE : REQ;
`endif
         end
         REQ: state_d = WAIT;
         // the read issued in REQ lands now; hand it straight to the serialiser
         WAIT: begin
            tx_valid = 1'b1;
            state_d  = START;
`ifdef UART_TX_CHECKSUM_EN
            chk_d = chk_q ^ mem.mem_data;
`endif
         end
         // o_ready rises in the last stop-bit cycle, so REQ/WAIT form the 2-cycle gap
         START: if (tx_ready) begin
`ifdef UART_TX_CHECKSUM_EN
            state_d = chk_sent_q ? DONE : more ? REQ : CHK;
            idx_d   = !chk_sent_q && more ? idx_q + 16'd1 : idx_q;
`else
            state_d = more ? REQ : DONE;
            idx_d   = more ? idx_q + 16'd1 : idx_q;
`endif
         end
`ifdef UART_TX_CHECKSUM_EN
         CHK: begin
            tx_valid   = 1'b1;
            tx_byte    = chk_q;
            chk_sent_d = 1'b1;
            state_d    = START;
         end
`endif
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         total_q <= '0;
         idx_q   <= '0;
`ifdef UART_TX_CHECKSUM_EN
         chk_q      <= '0;
         chk_sent_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         total_q <= total_d;
         idx_q   <= idx_d;
`ifdef UART_TX_CHECKSUM_EN
         chk_q      <= chk_d;
         chk_sent_q <= chk_sent_d;
`endif
      end
   end
   assign mem.mem_r_en = state_q == REQ;
   assign mem.mem_addr = state_q == REQ ? base_q + ADDR_W'(idx_q) : '0;
   assign o_busy       = state_q != IDLE && state_q != DONE;
   assign o_done       = state_q == DONE;
   uart_tx_byte #(.DIV(DIV)) u_tx (
      .clk     (clk),
      .rst     (rst),
      .i_valid (tx_valid),
      .i_byte  (tx_byte),
      .o_tx    (o_tx),
      .o_ready (tx_ready)
   );
endmodule

// File: tb/tb_filtered_image_uart_tx.sv
// tb_filtered_image_uart_tx: randomized dumps decoded off the UART line and compared to a pixel-list model
module tb_filtered_image_uart_tx;
   localparam int D = 4;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_start = 1'b0;
   logic [31:0] i_base_addr = '0;
   logic [7:0]  i_h = '0;
   logic [7:0]  i_w = '0;
   logic        o_tx, o_busy, o_done;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  mem_arr [logic [31:0]];
   logic        line_q [$];
   filtered_image_uart_tx_if #(.ADDR_W(32)) bus ();
   filtered_image_uart_tx #(.CLK_FREQ(4), .BAUD(1), .ADDR_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (i_start),
      .i_base_addr (i_base_addr),
      .i_h         (i_h),
      .i_w         (i_w),
      .mem         (bus.master),
      .o_tx        (o_tx),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );
   always #5 clk = ~clk;
   function automatic logic [7:0] pix(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return a[7:0] ^ a[15:8] ^ {a[3:0], a[7:4]} ^ 8'h3C;
   endfunction
   // memory answers one cycle after the strobe and drives garbage otherwise
   always @(posedge clk) bus.mem_data <= bus.mem_r_en ? pix(bus.mem_addr) : 8'($urandom);
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic run_dump(input logic [31:0] base, input logic [7:0] h, input logic [7:0] w,
                           input int inj_at, input int abort_at, input string tag);
      int          total, done_t, done_n, busy_bad, bad_w, i, j;
      logic [31:0] rd [$];
      logic [7:0]  exp_b [$];
      logic [7:0]  got_b [$];
      int          gaps [$];
      logic [7:0]  x, by;
      logic        eb;
      total = int'(h) * int'(w);
      x = '0;
      for (int k = 0; k < total; k++) begin
         exp_b.push_back(pix(base + 32'(k)));
         x ^= pix(base + 32'(k));
      end
`ifdef UART_TX_CHECKSUM_EN
      exp_b.push_back(x);
`endif
      line_q.delete();
      done_t = -1; done_n = 0; busy_bad = 0; bad_w = 0;
      i_base_addr = base; i_h = h; i_w = w; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0; i_base_addr = $urandom; i_h = 8'($urandom); i_w = 8'($urandom);
      for (int t = 0; t < 4000; t++) begin
         if (t == abort_at) begin
            check({tag, " pre_abort_tx"}, 32'(o_tx), 32'd0);
            rst = 1'b0;
            #1;
            check({tag, " rst_tx"}, 32'(o_tx), 32'd1);
            check({tag, " rst_busy"}, 32'(o_busy), 32'd0);
            check({tag, " rst_done"}, 32'(o_done), 32'd0);
            check({tag, " rst_ren"}, 32'(bus.mem_r_en), 32'd0);
            check({tag, " rst_addr"}, bus.mem_addr, 32'd0);
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            return;
         end
         i_start = t == inj_at;
         if (t == inj_at) i_h = h + 8'd1;
         line_q.push_back(o_tx);
         if (bus.mem_r_en) rd.push_back(bus.mem_addr);
         if (o_done) begin
            done_t = t;
            break;
         end
         if (!o_busy) busy_bad++;
         @(posedge clk); #1;
      end
      i_start = 1'b0;
      check({tag, " done_seen"}, 32'(done_t >= 0), 32'd1);
      check({tag, " busy_at_done"}, 32'(o_busy), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (o_done) done_n++;
         if (!o_tx) bad_w++;
      end
      check({tag, " extra_done"}, done_n, 0);
      i = 0;
      while (i < line_q.size()) begin
         j = i;
         while (j < line_q.size() && line_q[j]) j++;
         if (j >= line_q.size()) break;
         gaps.push_back(j - i);
         if (j + 10 * D > line_q.size()) begin
            bad_w++;
            break;
         end
         for (int b = 0; b < 8; b++) by[b] = line_q[j + (b + 1) * D + D / 2];
         got_b.push_back(by);
         for (int k = 0; k < 10; k++) begin
            eb = k == 0 ? 1'b0 : k == 9 ? 1'b1 : by[k-1];
            for (int c = 0; c < D; c++) if (line_q[j + k * D + c] !== eb) bad_w++;
         end
         i = j + 10 * D;
      end
      check({tag, " bytes_n"}, got_b.size(), exp_b.size());
      for (int k = 0; k < exp_b.size() && k < got_b.size(); k++)
         check($sformatf("%s byte%0d", tag, k), 32'(got_b[k]), 32'(exp_b[k]));
      check({tag, " bit_shape"}, bad_w, 0);
      for (int k = 0; k < gaps.size() && k < total; k++)
         check($sformatf("%s gap%0d", tag, k), gaps[k], 2);
      check({tag, " reads_n"}, rd.size(), total);
      for (int k = 0; k < rd.size() && k < total; k++)
         check($sformatf("%s addr%0d", tag, k), rd[k], base + 32'(k));
      check({tag, " busy_gaps"}, busy_bad, 0);
`ifndef UART_TX_CHECKSUM_EN
      check({tag, " done_time"}, done_t, total * (10 * D + 2));
`endif
   endtask
   initial begin
      logic [9:0]  a5_pat;
      logic [31:0] rb;
      logic [7:0]  rh, rw;
      for (int k = 0; k < 6; k++) mem_arr[32'h100 + 32'(k)] = 8'(k + 1);
      mem_arr[32'h200] = 8'h5C;
      mem_arr[32'h300] = 8'hA5;
      mem_arr[32'h400] = 8'h0F;
      mem_arr[32'h401] = 8'hF0;
      mem_arr[32'h402] = 8'h33;
      #2 rst = 1'b0;
      #10;
      check("reset tx", 32'(o_tx), 32'd1);
      check("reset busy", 32'(o_busy), 32'd0);
      check("reset done", 32'(o_done), 32'd0);
      check("reset ren", 32'(bus.mem_r_en), 32'd0);
      check("reset addr", bus.mem_addr, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run_dump(32'h100, 8'd2, 8'd3, -1, -1, "plan6");
      run_dump(32'h100, 8'd0, 8'd5, -1, -1, "zero");
      run_dump(32'h100, 8'd2, 8'd3, 30, -1, "inject");
      run_dump(32'h100, 8'd2, 8'd3, -1, 107, "abort");
      run_dump(32'h200, 8'd1, 8'd1, -1, -1, "after_rst");
      run_dump(32'h300, 8'd1, 8'd1, -1, -1, "a5");
      a5_pat = 10'b1101001010;
      for (int k = 0; k < 10; k++)
         check($sformatf("a5 line%0d", k), 32'(line_q[2 + k * D + D / 2]), 32'(a5_pat[k]));
      run_dump(32'h400, 8'd1, 8'd3, -1, -1, "chk3");
      for (int r = 0; r < 6; r++) begin
         rb = r == 0 ? 32'hFFFF_FFFE : $urandom;
         rh = 8'($urandom_range(0, 3));
         rw = 8'($urandom_range(0, 4));
         run_dump(rb, rh, rw, -1, -1, $sformatf("rnd%0d", r));
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
